mtr_duty_ramp: RTL and testbench

Slew-limited duty scheduler for the left/right 11-bit motor PWM pair. Accepts signed speed targets over a valid/ready handshake, walks each channel's actual duty toward its target by at most STEP per PWM period, and commits changes only on PWM period boundaries. Drives the duty inputs of both PWM instances and their direction bits. Brake input forces a fast ramp to zero. Sits between the motion/command logic and the two PWM generators.

---
 rtl/mtr_duty_ramp.sv | 119 +++++++++++
 tb/tb_mtr_duty_ramp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mtr_duty_ramp.sv
// Slew-limited duty scheduler for the left/right motor PWM pair: walks each
// channel's signed actual duty toward its target once per PWM period.

module mtr_ramp_lane (
    input  logic [11:0] act,
    input  logic [11:0] tg,
    input  logic [10:0] step,
    output logic [11:0] act_stp,
    output logic [10:0] duty,
    output logic        fwd
);
    logic [12:0] d;
    logic [12:0] d_abs;
    logic [11:0] act_neg;

    always_comb begin
        // Sign-extended 13-bit difference: tg - act spans -4094..4094.
        d       = {tg[11], tg} - {act[11], act};
        d_abs   = d[12] ? (13'd0 - d) : d;
        act_neg = 12'd0 - act;
        if (d_abs <= {2'b00, step})
            act_stp = tg;
        else if (d[12])
            act_stp = act - {1'b0, step};
        else
            act_stp = act + {1'b0, step};
        duty = act[11] ? act_neg[10:0] : act[10:0];
        fwd  = ~act[11];
    end
endmodule

module mtr_duty_ramp #(
    parameter logic [10:0] STEP    = 11'd32,
    parameter int          BRK_MUL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [11:0] lft_tgt,
    input  logic [11:0] rght_tgt,
    input  logic        brake,
    output logic [10:0] lft_duty,
    output logic        lft_fwd,
    output logic [10:0] rght_duty,
    output logic        rght_fwd,
    output logic        period_end,
    output logic        busy
);
    localparam int          NUM_LANES = 2;   // lane 0 = left, lane 1 = right
    localparam logic [10:0] BRK_STEP  = 11'(int'(STEP) * BRK_MUL);

    typedef enum logic [1:0] {IDLE, RAMP, BRAKE} state_t;

    state_t state, state_nxt;
    logic [10:0] cnt;
    logic        xfer;
    logic [10:0] step_sz;
    logic [NUM_LANES-1:0][11:0] act, tg, act_stp, tgt_in;
    logic [NUM_LANES-1:0][10:0] duty;
    logic [NUM_LANES-1:0]       fwd;

    // -2048 has no 11-bit magnitude, so it is pulled in to -2047.
    function automatic logic [11:0] clamp_tgt(input logic [11:0] t);
        return (t == 12'h800) ? 12'h801 : t;
    endfunction

    assign period_end = (cnt == 11'h7FF);
    assign cmd_rdy    = (state != BRAKE) && !brake;
    assign xfer       = cmd_vld && cmd_rdy;
    assign busy       = (state != IDLE);
    assign step_sz    = (state == BRAKE) ? BRK_STEP : STEP;
    assign tgt_in[0]  = clamp_tgt(lft_tgt);
    assign tgt_in[1]  = clamp_tgt(rght_tgt);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mtr_ramp_lane u_lane (
            .act     (act[i]),
            .tg      (tg[i]),
            .step    (step_sz),
            .act_stp (act_stp[i]),
            .duty    (duty[i]),
            .fwd     (fwd[i])
        );
    end

    assign lft_duty  = duty[0];
    assign lft_fwd   = fwd[0];
    assign rght_duty = duty[1];
    assign rght_fwd  = fwd[1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (xfer && (tgt_in != act)) state_nxt = RAMP;
            // A retarget on the boundary edge defers the idle decision a period.
            RAMP:  if (period_end && !xfer && (act_stp == tg)) state_nxt = IDLE;
            BRAKE: if (!brake && (act == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (brake) state_nxt = BRAKE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            act   <= '0;
            tg    <= '0;
            state <= IDLE;
        end else begin
            cnt   <= cnt + 11'd1;
            state <= state_nxt;
            if (period_end) act <= act_stp;
            // Steps above see the old targets; new ones apply next boundary.
            if (brake)     tg <= '0;
            else if (xfer) tg <= tgt_in;
        end
    end
endmodule

// File: tb/tb_mtr_duty_ramp.sv
// Bench for mtr_duty_ramp: table of per-boundary expectations fed through a
// scoreboard queue, plus hand sequences for brake release, reset and clamp.

module tb_mtr_duty_ramp;
    logic        clk = 1'b0;
    logic        rst, cmd_vld, brake, cmd_rdy, lft_fwd, rght_fwd, period_end, busy;
    logic [11:0] lft_tgt, rght_tgt;
    logic [10:0] lft_duty, rght_duty;

    logic        b_rst, b_vld, b_brake, b_rdy, b_lfwd, b_rfwd, b_pe, b_busy;
    logic [11:0] b_lt, b_rt;
    logic [10:0] b_ld, b_rd;
    logic        b_done = 1'b0;

    always #5 clk = ~clk;

    mtr_duty_ramp u_dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .lft_tgt(lft_tgt), .rght_tgt(rght_tgt), .brake(brake),
        .lft_duty(lft_duty), .lft_fwd(lft_fwd), .rght_duty(rght_duty),
        .rght_fwd(rght_fwd), .period_end(period_end), .busy(busy)
    );

    // Large-step instance so a full-scale ramp fits in a short run.
    mtr_duty_ramp #(.STEP(11'd511), .BRK_MUL(4)) u_big (
        .clk(clk), .rst(b_rst), .cmd_vld(b_vld), .cmd_rdy(b_rdy),
        .lft_tgt(b_lt), .rght_tgt(b_rt), .brake(b_brake),
        .lft_duty(b_ld), .lft_fwd(b_lfwd), .rght_duty(b_rd),
        .rght_fwd(b_rfwd), .period_end(b_pe), .busy(b_busy)
    );

    typedef struct {
        logic [10:0] ld; logic lf; logic [10:0] rd; logic rf; logic bsy; logic rdy;
    } exp_t;
    typedef struct {
        logic snd; logic [11:0] lt; logic [11:0] rt; logic brk; exp_t e;
    } vec_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string nm, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic add(logic snd, int lt, int rt, logic brk, int ld, logic lf,
                       int rd, logic rf, logic bsy, logic rdy);
        vec_t v;
        v.snd = snd; v.lt = 12'(lt); v.rt = 12'(rt); v.brk = brk;
        v.e.ld = 11'(ld); v.e.lf = lf; v.e.rd = 11'(rd); v.e.rf = rf;
        v.e.bsy = bsy; v.e.rdy = rdy;
        tbl.push_back(v);
    endtask

    task automatic send(logic [11:0] lt, logic [11:0] rt);
        @(negedge clk);
        lft_tgt = lt; rght_tgt = rt; cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    task automatic wait_pe();
        bit ok = 1'b0;
        for (int i = 0; i < 4100; i++) begin
            @(negedge clk);
            if (period_end) begin ok = 1'b1; break; end
        end
        if (!ok) chk("period_end timeout", 0, 1);
    endtask

    // Returns just after the boundary edge, where the new duty is visible.
    task automatic boundary();
        wait_pe();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_exp(string nm, exp_t e);
        chk({nm, " lft_duty"}, lft_duty, e.ld);
        chk({nm, " lft_fwd"}, lft_fwd, e.lf);
        chk({nm, " rght_duty"}, rght_duty, e.rd);
        chk({nm, " rght_fwd"}, rght_fwd, e.rf);
        chk({nm, " busy"}, busy, e.bsy);
        chk({nm, " cmd_rdy"}, cmd_rdy, e.rdy);
    endtask

    task automatic run_range(int lo, int hi);
        for (int i = lo; i < hi; i++) begin
            vec_t v = tbl[i];
            exp_t e;
            if (v.snd) send(v.lt, v.rt);
            @(negedge clk);
            brake = v.brk;
            sbq.push_back(v.e);
            boundary();
            e = sbq.pop_front();
            cmp_exp($sformatf("vec%0d", i), e);
        end
    endtask

    initial begin
        int n1, n2, n3, n;
        exp_t e;
        rst = 1'b1; cmd_vld = 1'b0; brake = 1'b0; lft_tgt = '0; rght_tgt = '0;

        // Forward ramp to 100, then to 400, then brake from 400 with tg 1000.
        add(1, 100, 0, 0,  32, 1, 0, 1, 1, 1);
        add(0,   0, 0, 0,  64, 1, 0, 1, 1, 1);
        add(0,   0, 0, 0,  96, 1, 0, 1, 1, 1);
        add(0,   0, 0, 0, 100, 1, 0, 1, 0, 1);
        add(1, 400, 0, 0, 132, 1, 0, 1, 1, 1);
        for (int k = 1; k <= 8; k++) add(0, 0, 0, 0, 132 + 32 * k, 1, 0, 1, 1, 1);
        add(0,    0, 0, 0, 400, 1, 0, 1, 0, 1);
        add(1, 1000, 0, 1, 272, 1, 0, 1, 1, 0);
        add(0,    0, 0, 1, 144, 1, 0, 1, 1, 0);
        add(0,    0, 0, 1,  16, 1, 0, 1, 1, 0);
        add(0,    0, 0, 1,   0, 1, 0, 1, 1, 0);
        n1 = tbl.size();
        // Up to +64, reversal to -64, then a ramp that reset will interrupt.
        add(1,   64, 0, 0, 32, 1, 0, 1, 1, 1);
        add(0,    0, 0, 0, 64, 1, 0, 1, 0, 1);
        add(1,  -64, 0, 0, 32, 1, 0, 1, 1, 1);
        add(0,    0, 0, 0,  0, 1, 0, 1, 1, 1);
        add(0,    0, 0, 0, 32, 0, 0, 1, 1, 1);
        add(0,    0, 0, 0, 64, 0, 0, 1, 0, 1);
        add(1, 1000, 0, 0, 32, 0, 0, 1, 1, 1);
        n2 = tbl.size();
        // Retarget from +500 down to +40 at act = 96.
        add(1, 500, 0, 0, 32, 1, 0, 1, 1, 1);
        add(0,   0, 0, 0, 64, 1, 0, 1, 1, 1);
        add(0,   0, 0, 0, 96, 1, 0, 1, 1, 1);
        add(1,  40, 0, 0, 64, 1, 0, 1, 1, 1);
        add(0,   0, 0, 0, 40, 1, 0, 1, 0, 1);
        n3 = tbl.size();

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset lft_duty", lft_duty, 0);
        chk("reset lft_fwd", lft_fwd, 1);
        chk("reset rght_duty", rght_duty, 0);
        chk("reset rght_fwd", rght_fwd, 1);
        chk("reset busy", busy, 0);
        chk("reset cmd_rdy", cmd_rdy, 1);
        chk("reset period_end", period_end, 0);

        run_range(0, n1);
        @(negedge clk);
        brake = 1'b0;
        @(posedge clk);
        #1;
        chk("brake release busy", busy, 0);
        chk("brake release cmd_rdy", cmd_rdy, 1);
        chk("brake release lft_duty", lft_duty, 0);

        run_range(n1, n2);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid rst lft_duty", lft_duty, 0);
        chk("mid rst lft_fwd", lft_fwd, 1);
        chk("mid rst rght_duty", rght_duty, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst cmd_rdy", cmd_rdy, 1);
        chk("mid rst period_end", period_end, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 4100; i++) begin
            @(negedge clk);
            n++;
            if (period_end) break;
        end
        chk("first period_end after rst", n, 2047);
        @(posedge clk);
        #1;

        run_range(n2, n3);

        // Transfer of -2048 landing exactly on the boundary edge.
        wait_pe();
        lft_tgt = 12'd40; rght_tgt = 12'h800; cmd_vld = 1'b1;
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        chk("collision rght_duty", rght_duty, 0);
        chk("collision rght_fwd", rght_fwd, 1);
        chk("collision lft_duty", lft_duty, 40);
        chk("collision busy", busy, 1);
        e.ld = 11'd40; e.lf = 1'b1; e.rd = 11'd32; e.rf = 1'b0; e.bsy = 1'b1; e.rdy = 1'b1;
        sbq.push_back(e);
        boundary();
        e = sbq.pop_front();
        cmp_exp("clamp first step", e);

        chk("big ramp done", b_done, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Full-scale clamp ramp on the STEP = 511 instance, running concurrently.
    initial begin
        int big_exp[5] = '{511, 1022, 1533, 2044, 2047};
        b_rst = 1'b1; b_vld = 1'b0; b_brake = 1'b0; b_lt = '0; b_rt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        b_rst = 1'b0;
        @(negedge clk);
        b_rt = 12'h800; b_vld = 1'b1;
        @(negedge clk);
        b_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bit ok = 1'b0;
            for (int i = 0; i < 4100; i++) begin
                @(negedge clk);
                if (b_pe) begin ok = 1'b1; break; end
            end
            if (!ok) chk("big period_end timeout", 0, 1);
            @(posedge clk);
            #1;
            chk($sformatf("big step%0d rght_duty", k), b_rd, big_exp[k]);
            chk($sformatf("big step%0d rght_fwd", k), b_rfwd, 0);
            chk($sformatf("big step%0d busy", k), b_busy, (k < 4) ? 1 : 0);
        end
        b_done = 1'b1;
    end
endmodule
